// File: rtl/if_fetch.sv
// Instruction fetch for the 5-stage RV32I pipeline: builds each word from four
// byte reads, predicts the next pc statically and presents pc/inst to IF/ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter bit          STATIC_PRED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [7:0]  mem_data_i,
    output logic        inst_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        jmp_status_o
);

    typedef enum logic {FETCH, VALID} state_e;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        jmp;
    } ifid_t;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [2:0]  req_cnt_q, req_cnt_d;
    logic [2:0]  rcv_cnt_q, rcv_cnt_d;
    logic        drop_q, drop_d;
    logic [31:0] asm_q, asm_d;
    ifid_t       out_q, out_d;

    logic        granted;
    logic        outstanding;
    logic        take;
    logic [31:0] asm_new;
    logic [32:0] pred;

    // {taken, next_pc}; JAL and backward branches are predicted taken
    function automatic logic [32:0] predict(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] jal_imm;
        logic [31:0] br_imm;
        jal_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        br_imm  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (STATIC_PRED && w[6:0] == 7'b1101111)
            return {1'b1, pc + jal_imm};
        if (STATIC_PRED && w[6:0] == 7'b1100011 && w[31])
            return {1'b1, pc + br_imm};
        return {1'b0, pc + 32'd4};
    endfunction

    assign mem_req_o    = ~rst & rdy & (state_q == FETCH) & ~req_cnt_q[2];
    assign mem_addr_o   = rst ? 32'h0 : pc_q + {30'h0, req_cnt_q[1:0]};
    assign inst_valid_o = out_q.vld;
    assign pc_o         = out_q.pc;
    assign inst_o       = out_q.inst;
    assign jmp_status_o = out_q.jmp;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        npc_d     = npc_q;
        req_cnt_d = req_cnt_q;
        rcv_cnt_d = rcv_cnt_q;
        drop_d    = drop_q;
        asm_d     = asm_q;
        out_d     = out_q;

        granted     = mem_req_o & mem_gnt_i;
        outstanding = req_cnt_q != rcv_cnt_q;
        take        = mem_rvalid_i & ~drop_q & outstanding;
        asm_new     = asm_q;
        if (take)
            asm_new[{rcv_cnt_q[1:0], 3'b000} +: 8] = mem_data_i;
        pred = predict(pc_q, asm_new);

        if (jmp_i) begin
            // anything granted now or still in flight belongs to the old path
            pc_d      = jmp_target_i;
            req_cnt_d = 3'd0;
            rcv_cnt_d = 3'd0;
            out_d.vld = 1'b0;
            state_d   = FETCH;
            drop_d    = granted | ((outstanding | drop_q) & ~mem_rvalid_i);
        end else begin
            if (drop_q && mem_rvalid_i)
                drop_d = 1'b0;
            case (state_q)
                FETCH: begin
                    if (granted)
                        req_cnt_d = req_cnt_q + 3'd1;
                    if (take) begin
                        asm_d     = asm_new;
                        rcv_cnt_d = rcv_cnt_q + 3'd1;
                        if (rcv_cnt_q == 3'd3) begin
                            state_d = VALID;
                            out_d   = '{vld: 1'b1, pc: pc_q, inst: asm_new, jmp: pred[32]};
                            npc_d   = pred[31:0];
                        end
                    end
                end
                VALID: begin
                    if (!stall_i) begin
                        out_d.vld = 1'b0;
                        pc_d      = npc_q;
                        req_cnt_d = 3'd0;
                        rcv_cnt_d = 3'd0;
                        state_d   = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            npc_q     <= 32'h0;
            req_cnt_q <= 3'd0;
            rcv_cnt_q <= 3'd0;
            drop_q    <= 1'b0;
            asm_q     <= 32'h0;
            out_q     <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            npc_q     <= npc_d;
            req_cnt_q <= req_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
            drop_q    <= drop_d;
            asm_q     <= asm_d;
            out_q     <= out_d;
        end
    end

endmodule
